// File: rtl/alu_seq_muldiv.sv
// ---------------------------------------------------------------------------------------------
// alu_seq_muldiv: multi-cycle ALU with iterative multiply / divide behind valid/ready handshakes.
//
// Base ops (ADD..SLTU) and illegal codes finish on the accept edge. Multiply, divide and
// remainder ops run XLEN shift-add / restoring-division iterations, then take one correction
// cycle. Result and Zero are registered and held until the consumer takes them.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only)
//   A, B       operands, captured on accept
//   ALUOp      operation code, captured on accept
//   out_valid  Result/Zero valid, held until out_ready
//   out_ready  consumer takes the result
//   Result     registered result
//   Zero       registered (Result == 0)
//   Busy       long op in progress (CALC or FIX)
// ---------------------------------------------------------------------------------------------
module alu_seq_muldiv #(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALUOp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Busy
);

    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpAnd    = 5'd2;
    localparam logic [4:0] OpOr     = 5'd3;
    localparam logic [4:0] OpXor    = 5'd4;
    localparam logic [4:0] OpSll    = 5'd5;
    localparam logic [4:0] OpSrl    = 5'd6;
    localparam logic [4:0] OpSra    = 5'd7;
    localparam logic [4:0] OpSlt    = 5'd8;
    localparam logic [4:0] OpSltu   = 5'd9;
    localparam logic [4:0] OpMul    = 5'd10;
    localparam logic [4:0] OpMulh   = 5'd11;
    localparam logic [4:0] OpMulhsu = 5'd12;
    localparam logic [4:0] OpMulhu  = 5'd13;
    localparam logic [4:0] OpDiv    = 5'd14;
    localparam logic [4:0] OpDivu   = 5'd15;
    localparam logic [4:0] OpRem    = 5'd16;
    localparam logic [4:0] OpRemu   = 5'd17;

    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LastCnt = SHW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q;
    logic [4:0]        op_q;
    logic [SHW-1:0]    cnt_q;
    // hi_q: product high half / partial remainder; lo_q: multiplier / quotient being built
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    // dv_q: multiplicand or divisor magnitude
    logic [XLEN-1:0]   dv_q;
    logic [XLEN-1:0]   a_raw_q;
    logic              neg_q;
    logic              div_zero_q;
    logic              ovf_q;

    // ------------------------------------------------------------------
    // Base (single-cycle) operations, evaluated on the live inputs
    // ------------------------------------------------------------------
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    assign shamt = B[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (ALUOp)
            OpAdd:   base_res = A + B;
            OpSub:   base_res = A - B;
            OpAnd:   base_res = A & B;
            OpOr:    base_res = A | B;
            OpXor:   base_res = A ^ B;
            OpSll:   base_res = A << shamt;
            OpSrl:   base_res = A >> shamt;
            OpSra:   base_res = $unsigned($signed(A) >>> shamt);
            OpSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            OpSltu:  base_res = {{(XLEN-1){1'b0}}, A < B};
            default: base_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Long-op setup: the iterative core always works on magnitudes
    // ------------------------------------------------------------------
    logic            is_long;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            res_neg;

    always_comb begin
        is_long  = (ALUOp >= OpMul) && (ALUOp <= OpRemu);
        // MUL keeps both operands unsigned: the low half is sign-agnostic
        a_signed = (ALUOp == OpMulh) || (ALUOp == OpMulhsu) || (ALUOp == OpDiv) ||
                   (ALUOp == OpRem);
        b_signed = (ALUOp == OpMulh) || (ALUOp == OpDiv) || (ALUOp == OpRem);
        a_neg    = a_signed & A[XLEN-1];
        b_neg    = b_signed & B[XLEN-1];
        a_mag    = a_neg ? ('0 - A) : A;
        b_mag    = b_neg ? ('0 - B) : B;
        // Remainder takes the dividend's sign; products and quotients take the xor
        res_neg  = (ALUOp == OpRem) ? a_neg : (a_neg ^ b_neg);
    end

    // ------------------------------------------------------------------
    // One iteration step: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic            is_mul_q;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    always_comb begin
        is_mul_q  = (op_q <= OpMulhu);
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, dv_q};
        div_ge    = (div_shift >= {1'b0, dv_q});
        if (is_mul_q) begin
            // {carry, hi, lo} >> 1 after the conditional add
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end
    end

    // ------------------------------------------------------------------
    // Final correction: signs and divide special cases
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_q ? ('0 - {hi_q, lo_q}) : {hi_q, lo_q};
        quo_fix  = neg_q ? ('0 - lo_q) : lo_q;
        rem_fix  = neg_q ? ('0 - hi_q) : hi_q;
        fix_res  = '0;
        case (op_q)
            OpMul:    fix_res = prod_fix[XLEN-1:0];
            OpMulh,
            OpMulhsu,
            OpMulhu:  fix_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv:    fix_res = div_zero_q ? '1 : (ovf_q ? a_raw_q : quo_fix);
            OpDivu:   fix_res = div_zero_q ? '1 : lo_q;
            OpRem:    fix_res = div_zero_q ? a_raw_q : (ovf_q ? '0 : rem_fix);
            OpRemu:   fix_res = div_zero_q ? a_raw_q : hi_q;
            default:  fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            Busy       <= 1'b0;
            Result     <= '0;
            Zero       <= 1'b1;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dv_q       <= '0;
            a_raw_q    <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_long) begin
                            op_q       <= ALUOp;
                            hi_q       <= '0;
                            lo_q       <= a_mag;
                            dv_q       <= b_mag;
                            a_raw_q    <= A;
                            neg_q      <= res_neg;
                            div_zero_q <= (B == '0);
                            ovf_q      <= (A == MinNeg) && (B == '1);
                            cnt_q      <= '0;
                            Busy       <= 1'b1;
                            state_q    <= StCalc;
                        end else begin
                            Result    <= base_res;
                            Zero      <= (base_res == '0);
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    // Wraps back to zero on the last iteration
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    Result    <= fix_res;
                    Zero      <= (fix_res == '0);
                    Busy      <= 1'b0;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, multi-cycle successor to the processor's single-cycle ALU.
- Keeps the ten base integer ops and adds the RV32M-style multiply, divide and remainder ops, implemented iteratively (shift-add / restoring).
- Sits in the execute stage behind a valid/ready handshake, so the core stalls while a long op runs.
- Result and Zero are registered.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- A  input  XLEN  operand A.
- B  input  XLEN  operand B.
- ALUOp  input  5  operation code.
- out_valid  output  1  Result/Zero valid; held until consumed.
- out_ready  input  1  consumer takes the result.
- Result  output  XLEN  registered result.
- Zero  output  1  registered (Result == 0).
- Busy  output  1  high in CALC or FIX.

Behaviour:
- Reset values (rst high at a clock edge, any state, including mid-operation):
  - state = IDLE, in_ready = 1, out_valid = 0, Busy = 0.
  - Result = 0, Zero = 1, iteration counter = 0.
  - Any op in flight is discarded.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. A, B and ALUOp are captured then; later changes are ignored until the next accept.
- ALUOp encoding:
  - Base ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - Long ops: 10 MUL (low XLEN bits), 11 MULH (s×s high), 12 MULHSU (s×u high), 13 MULHU (u×u high), 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18–31 are illegal: Result = 0, handled as base-op latency.
- Shifts use B[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended to XLEN. ADD/SUB wrap modulo 2^XLEN.
- State machine: IDLE, CALC, FIX, DONE.
  - IDLE: in_ready = 1.
    - Accept of a base/illegal op: compute, load Result/Zero, go to DONE.
    - Accept of a long op: operands converted to magnitudes per signedness, counter = 0, go to CALC.
  - CALC: one multiplier or quotient bit per cycle. Counter increments; leaves to FIX after exactly XLEN cycles (counter == XLEN-1).
  - FIX: one cycle. Applies sign correction and special cases, loads Result/Zero, goes to DONE.
  - DONE: out_valid = 1; Result/Zero stable.
    - out_ready high: go to IDLE (out_valid low next cycle).
    - out_ready low: hold indefinitely.
- Latency, counted in edges after the accept edge until out_valid is first high:
  - Base/illegal ops: 1.
  - Long ops: XLEN+2.
  - The latency is fixed and does not depend on data.
- Throughput: there is one bubble minimum between results, because in_ready is low in DONE.
- Special cases (resolved in FIX; the long-op latency is unchanged):
  - Divide by zero: DIV and DIVU return all-ones; REM and REMU return A.
  - Signed overflow (A = most negative, B = -1): DIV returns A; REM returns 0.
- Signs:
  - Remainder sign follows the dividend.
  - Quotient is truncated toward zero.
  - MULH/MULHSU high half is the exact 2·XLEN-bit signed product's upper half.
- Zero is always recomputed from the loaded Result value.
- in_valid while in_ready is low is ignored; there is no queueing.
- out_ready while out_valid is low has no effect.

Test Plan:
- Reset with rst=1 for 2 cycles, then release → in_ready=1, out_valid=0, Result=0, Zero=1, Busy=0.
- ADD: A=0xFFFFFFFF, B=1, op 0 → out_valid 1 cycle after accept; Result=0, Zero=1. SRA: A=0x80000000, B=0x24 (shift 4) → 0xF8000000.
- MULH: A=0x80000000, B=0x80000000 → Result=0x40000000 at edge 34. MULHU: A=B=0xFFFFFFFF → 0xFFFFFFFE. MUL: A=-3, B=7 → 0xFFFFFFEB.
- DIV: A=-7, B=2 → -3 (0xFFFFFFFD). REM with same operands → -1. DIVU: A=5, B=0 → 0xFFFFFFFF. REM: A=5, B=0 → 5. DIV: A=0x80000000, B=-1 → 0x80000000, and REM of the same → 0 with Zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after a DIVU result → out_valid and Result stable, in_ready=0, a second in_valid is ignored. Raise out_ready → IDLE next cycle, then the next request is accepted.
- Reset mid-CALC: assert rst at iteration 10 of a MUL → next cycle IDLE with all reset values. A new ADD 2+3 then returns 5 at latency 1.
